// File: rtl/op_queue_sequencer_if.sv
// Handshake bundle between the op source / processor and op_queue_sequencer.
// The op is carried as a packed Op_st image {opcode[39:32], x[31:16], y[15:0]}.
interface op_queue_sequencer_if #(
  parameter int DEPTH      = 8,
  parameter int COUNT_BITS = 16,
  parameter int OP_BITS    = 40
);
  localparam int LEVEL_BITS = $clog2(DEPTH) + 1;

  logic                  clk_en;
  logic [OP_BITS-1:0]    in_op;
  logic                  in_valid;
  logic                  in_rdy;
  logic [1:0]            mode;
  logic                  step;
  logic                  flush;
  logic [OP_BITS-1:0]    proc_op;
  logic                  proc_trigger;
  logic                  proc_rdy;
  logic [LEVEL_BITS-1:0] level;
  logic                  busy;
  logic [COUNT_BITS-1:0] done_count;
  logic                  timeout;

  // Sequencer side
  modport slave (
    input  clk_en, in_op, in_valid, mode, step, flush, proc_rdy,
    output in_rdy, proc_op, proc_trigger, level, busy, done_count, timeout
  );

  // Source / processor side
  modport master (
    output clk_en, in_op, in_valid, mode, step, flush, proc_rdy,
    input  in_rdy, proc_op, proc_trigger, level, busy, done_count, timeout
  );
endinterface

// File: rtl/op_queue_sequencer.sv
// Op queue and issue sequencer: buffers DEPTH ops, issues them one at a time
// over trigger/rdy, with run/pause/step modes, flush, done counter and watchdog.
module op_queue_sequencer #(
  parameter int DEPTH          = 8,
  parameter int COUNT_BITS     = 16,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int OP_BITS        = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  op_queue_sequencer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;

  state_t                state;
  state_t                state_next;
  logic [OP_BITS-1:0]    mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [LW-1:0]         level_q;
  logic [OP_BITS-1:0]    proc_op_q;
  logic                  trigger_q;
  logic                  busy_q;
  logic [COUNT_BITS-1:0] done_q;
  logic                  timeout_q;
  logic                  step_pending;
  logic [31:0]           wd_count;

  logic                  in_rdy_int;
  logic                  push;
  logic                  permit;
  logic                  wd_hit;
  logic                  issue;
  logic                  accept;
  logic                  complete;
  logic                  fire;

  assign in_rdy_int = (level_q != LW'(DEPTH)) && !timeout_q;
  assign push       = bus.in_valid && in_rdy_int && !bus.flush;
  assign permit     = (bus.mode == 2'd0) || ((bus.mode == 2'd2) && step_pending);
  assign wd_hit     = (TIMEOUT_CYCLES != 0) && ((wd_count + 32'd1) == 32'(TIMEOUT_CYCLES));

  assign bus.in_rdy       = in_rdy_int;
  assign bus.proc_op      = proc_op_q;
  assign bus.proc_trigger = trigger_q;
  assign bus.level        = level_q;
  assign bus.busy         = busy_q;
  assign bus.done_count   = done_q;
  assign bus.timeout      = timeout_q;

  // Next-state decode; flush blocks an issue, watchdog beats normal progress
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if ((level_q != '0) && bus.proc_rdy && permit && !bus.flush) begin
          state_next = ISSUE;
          issue      = 1'b1;
        end
      end
      ISSUE: begin
        if (wd_hit) begin
          state_next = HALT;
          fire       = 1'b1;
        end else if (!bus.proc_rdy) begin
          state_next = WAIT;
          accept     = 1'b1;
        end
      end
      WAIT: begin
        if (wd_hit) begin
          state_next = HALT;
          fire       = 1'b1;
        end else if (bus.proc_rdy) begin
          state_next = IDLE;
          complete   = 1'b1;
        end
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // State register, frozen while clk_en is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (bus.clk_en) begin
      state <= state_next;
    end
  end

  // Queue storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (bus.clk_en && push) begin
      mem[wr_ptr] <= bus.in_op;
    end
  end

  // Pointers, level, issue outputs, counters and watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level_q      <= '0;
      proc_op_q    <= '0;
      trigger_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= '0;
      timeout_q    <= 1'b0;
      step_pending <= 1'b0;
      wd_count     <= '0;
    end else if (bus.clk_en) begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (bus.flush) begin
        rd_ptr  <= wr_ptr;
        level_q <= '0;
      end else begin
        if (issue) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        level_q <= level_q + LW'(push) - LW'(issue);
      end
      if (issue) begin
        proc_op_q <= mem[rd_ptr];
        trigger_q <= 1'b1;
      end else if (accept || fire) begin
        trigger_q <= 1'b0;
      end
      busy_q <= (state_next == ISSUE) || (state_next == WAIT);
      if (complete) begin
        done_q <= done_q + COUNT_BITS'(1);
      end
      if (fire) begin
        timeout_q <= 1'b1;
      end
      step_pending <= (bus.mode == 2'd2) && (bus.step || (step_pending && !issue));
      if (issue) begin
        wd_count <= '0;
      end else if ((state == ISSUE) || (state == WAIT)) begin
        wd_count <= wd_count + 32'd1;
      end
    end
  end
endmodule
